iq_usb_packer: RTL

//  Sits between the two fir_dec outputs (I = sin path, Q = cos path) and the usb2 write side.
//  - Rounds and saturates each 32-bit FIR sample to 16 bits.
//  - Buffers I/Q pairs in a small FIFO.
//  - Serialises each pair as two 16-bit words (I first, then Q) on a valid/ready stream.
//  - Marks packet boundaries for PKTEND and counts dropped pairs.
//  - Runs entirely in the ADC clock domain.

---
 rtl/iq_usb_packer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/iq_usb_packer.sv
// Rounds/saturates FIR I/Q samples to 16 bits, queues pairs in a small FIFO and
// serialises them as I-then-Q words on a valid/ready stream with packet framing.
module iq_usb_packer #(
  parameter int DIN_W      = 32,
  parameter int DOUT_W     = 16,
  parameter int SHIFT      = 14,
  parameter int ROUND      = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_WORDS  = 512
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           din_val,
  input  logic [DIN_W-1:0]               idata,
  input  logic [DIN_W-1:0]               qdata,
  output logic [DOUT_W-1:0]              dout,
  output logic                           dout_val,
  input  logic                           dout_rdy,
  output logic                           dout_last,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [15:0]                    ovf_cnt,
  output logic                           sat_flag,
  input  logic                           ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (PKT_WORDS > 2) ? $clog2(PKT_WORDS) : 1;

  localparam logic signed [DIN_W:0] RND  = (ROUND != 0) ? (DIN_W+1)'(2 ** (SHIFT - 1)) : '0;
  localparam logic signed [DIN_W:0] MAXV = (DIN_W+1)'((2 ** (DOUT_W - 1)) - 1);
  localparam logic signed [DIN_W:0] MINV = -MAXV - (DIN_W+1)'(1);
  localparam logic [DOUT_W-1:0]     MAX_WORD = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0]     MIN_WORD = {1'b1, {(DOUT_W-1){1'b0}}};
  localparam logic [CW-1:0]         LAST_IDX = CW'(PKT_WORDS - 1);

  typedef enum logic {S_I, S_Q} state_e;

  typedef struct packed {
    logic [DOUT_W-1:0] i;
    logic [DOUT_W-1:0] q;
  } pair_t;

  // Returns {clipped, word}; the sum is one bit wider than the input so it never wraps.
  function automatic logic [DOUT_W:0] round_sat(input logic [DIN_W-1:0] d);
    logic signed [DIN_W:0] x;
    logic signed [DIN_W:0] y;
    x = $signed({d[DIN_W-1], d}) + RND;
    y = x >>> SHIFT;
    if (y > MAXV)      round_sat = {1'b1, MAX_WORD};
    else if (y < MINV) round_sat = {1'b1, MIN_WORD};
    else               round_sat = {1'b0, y[DOUT_W-1:0]};
  endfunction

  // ---------------- Stage 1: round and saturate ----------------
  logic [DOUT_W:0] i_rs;
  logic [DOUT_W:0] q_rs;
  logic            s1_val_q;
  pair_t           s1_pair_q;
  logic            sat_q;

  assign i_rs = round_sat(idata);
  assign q_rs = round_sat(qdata);

  // NOTE: sequential state uses non-blocking assignments so every register in this
  // block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_val_q  <= 1'b0;
      s1_pair_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      s1_val_q <= din_val;
      if (din_val) s1_pair_q <= '{i: i_rs[DOUT_W-1:0], q: q_rs[DOUT_W-1:0]};
      if (ovf_clr)                                    sat_q <= 1'b0;
      else if (din_val && (i_rs[DOUT_W] || q_rs[DOUT_W])) sat_q <= 1'b1;
    end
  end

  // ---------------- Pair FIFO ----------------
  pair_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [LW-1:0]  level_q;
  logic [15:0]    ovf_q;
  logic           wr_en, drop, pop;
  pair_t          head, head_next;
  logic           next_avail;

  // Full test uses the level before this cycle's pop: no pass-through when full.
  assign wr_en      = s1_val_q && (level_q < LW'(FIFO_DEPTH));
  assign drop       = s1_val_q && !wr_en;
  assign rd_ptr_nxt = rd_ptr_q + AW'(1);
  assign head       = mem_q[rd_ptr_q];
  assign head_next  = (level_q >= LW'(2)) ? mem_q[rd_ptr_nxt] : s1_pair_q;
  assign next_avail = (level_q >= LW'(2)) || ((level_q == LW'(1)) && wr_en);

  // NOTE: the storage array has no reset; level and pointers alone decide which
  // entries are valid, so clearing the contents would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s1_pair_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_nxt;
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (ovf_clr)                      ovf_q <= '0;
      else if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  // ---------------- Serialiser and packet counter ----------------
  state_e            state_q, state_d;
  logic [DOUT_W-1:0] dout_q, dout_d;
  logic              val_q, val_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              accept;

  assign accept = val_q && dout_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_I;
      dout_q  <= '0;
      val_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      val_q   <= val_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_d is the packet index of whichever word is presented next.
  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    val_d   = val_q;
    last_d  = last_q;
    pop     = 1'b0;
    cnt_d   = cnt_q;
    if (accept) cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CW'(1);

    case (state_q)
      S_I: begin
        if (!val_q) begin
          if (level_q != '0) begin
            dout_d = head.i;
            val_d  = 1'b1;
            last_d = (cnt_d == LAST_IDX);
          end
        end else if (dout_rdy) begin
          dout_d  = head.q;
          last_d  = (cnt_d == LAST_IDX);
          state_d = S_Q;
        end
      end
      S_Q: begin
        if (dout_rdy) begin
          pop     = 1'b1;
          state_d = S_I;
          if (next_avail) begin
            dout_d = head_next.i;
            val_d  = 1'b1;
            last_d = (cnt_d == LAST_IDX);
          end else begin
            val_d  = 1'b0;
            last_d = 1'b0;
          end
        end
      end
      default: state_d = S_I;
    endcase
  end

  assign dout       = dout_q;
  assign dout_val   = val_q;
  assign dout_last  = last_q;
  assign fifo_level = level_q;
  assign ovf_cnt    = ovf_q;
  assign sat_flag   = sat_q;

endmodule
